// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the FIR_HLS run sequencer.
package fir_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_IDLE = 3'd1,
    ST_START     = 3'd2,
    ST_RUN       = 3'd3,
    ST_ERROR     = 3'd4
  } seq_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_DEADLOCK = 2'd2;
  localparam logic [1:0] ERR_PROTOCOL = 2'd3;

  // START and RUN are the states in which a kernel invocation is in flight.
  function automatic logic is_supervised(seq_state_t s);
    return (s == ST_START) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/fir_seq_watchdog.sv
// Per-run cycle timeout counter and dl_block persistence counter.
// Both hit outputs are combinational on the current cycle so the
// sequencer can leave for ERROR at the edge ending the offending cycle.
module fir_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int BLOCK_PERSIST  = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic dl_block,
  output logic timeout_hit,
  output logic deadlock_hit
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BW = $clog2(BLOCK_PERSIST + 1);
  localparam logic [TW-1:0] TIMER_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] PERSIST_LAST = BW'(BLOCK_PERSIST - 1);

  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] persist_q, persist_d;

  // timer_q is the age of the current run (0 in the first START cycle);
  // persist_q counts earlier consecutive blocked supervised cycles.
  always_comb begin
    timer_d   = timer_q;
    persist_d = '0;
    if (clear) begin
      timer_d = '0;
    end else if (enable && (timer_q != TIMER_LAST)) begin
      timer_d = timer_q + 1'b1;
    end
    if (enable && dl_block) begin
      persist_d = (persist_q == PERSIST_LAST) ? persist_q : persist_q + 1'b1;
    end
  end

  assign timeout_hit  = enable && (timer_q == TIMER_LAST);
  assign deadlock_hit = enable && dl_block && (persist_q == PERSIST_LAST);

  // Counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q   <= '0;
      persist_q <= '0;
    end else begin
      timer_q   <= timer_d;
      persist_q <= persist_d;
    end
  end

endmodule

// File: rtl/fir_run_sequencer.sv
// Issues a batch of FIR_HLS runs over ap_ctrl_hs, counts completions and
// drops into ERROR on timeout, persistent deadlock or a stray ap_done.
module fir_run_sequencer
  import fir_seq_pkg::*;
#(
  parameter int RUNS_W         = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int BLOCK_PERSIST  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic [RUNS_W-1:0] cmd_num_runs,
  input  logic              cmd_abort,
  output logic              ap_start,
  input  logic              ap_ready,
  input  logic              ap_done,
  input  logic              ap_idle,
  input  logic              dl_block,
  output logic              busy,
  output logic              batch_done,
  output logic [RUNS_W-1:0] runs_completed,
  output logic              err,
  output logic [1:0]        err_code
);

  seq_state_t        state_q, state_d;
  logic [RUNS_W-1:0] num_runs_q, num_runs_d;
  logic [RUNS_W-1:0] runs_q, runs_d;
  logic              ap_start_q, ap_start_d;
  logic              busy_q, busy_d;
  logic              batch_done_q, batch_done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              started_q, started_d;   // a batch has been accepted since reset
  logic              abort_q, abort_d;       // abort seen while a run was in flight
  logic              pend_q, pend_d;         // ap_done arrived together with ap_ready

  logic              wd_clear, wd_enable, timeout_hit, deadlock_hit;
  logic [RUNS_W:0]   runs_inc;
  logic              done_eff;
  logic [1:0]        fault;

  assign wd_enable = is_supervised(state_q);
  assign wd_clear  = (state_d == ST_START) && (state_q != ST_START);

  fir_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .BLOCK_PERSIST (BLOCK_PERSIST)
  ) u_watchdog (
    .clock       (clock),
    .reset       (reset),
    .clear       (wd_clear),
    .enable      (wd_enable),
    .dl_block    (dl_block),
    .timeout_hit (timeout_hit),
    .deadlock_hit(deadlock_hit)
  );

  // Next-state and registered-output logic; faults are collected in one
  // place so every error path sets state, err and err_code identically.
  always_comb begin
    state_d      = state_q;
    num_runs_d   = num_runs_q;
    runs_d       = runs_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    batch_done_d = 1'b0;
    started_d    = started_q;
    pend_d       = 1'b0;
    fault        = ERR_NONE;
    runs_inc     = {1'b0, runs_q} + 1'b1;
    done_eff     = ap_done || pend_q;

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if ((state_q == ST_IDLE) && ap_done && started_q) begin
          fault = ERR_PROTOCOL;
        end else if (cmd_start) begin
          started_d  = 1'b1;
          num_runs_d = cmd_num_runs;
          runs_d     = '0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          if (cmd_num_runs == '0) begin
            batch_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (ap_done) begin
          fault = ERR_PROTOCOL;
        end else if (cmd_abort) begin
          state_d = ST_IDLE;
        end else if (ap_idle) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (deadlock_hit) begin
          fault = ERR_DEADLOCK;
        end else if (ap_done && !ap_ready) begin
          fault = ERR_PROTOCOL;
        end else if (timeout_hit) begin
          fault = ERR_TIMEOUT;
        end else if (ap_ready) begin
          state_d = ST_RUN;
          pend_d  = ap_done;
        end
      end
      ST_RUN: begin
        if (deadlock_hit) begin
          fault = ERR_DEADLOCK;
        end else if (done_eff) begin
          runs_d = (&runs_q) ? runs_q : runs_inc[RUNS_W-1:0];
          if (abort_q || cmd_abort) begin
            state_d = ST_IDLE;
          end else if (runs_inc == {1'b0, num_runs_q}) begin
            batch_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_START;
          end
        end else if (timeout_hit) begin
          fault = ERR_TIMEOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fault != ERR_NONE) begin
      state_d    = ST_ERROR;
      err_d      = 1'b1;
      err_code_d = fault;
    end

    abort_d    = is_supervised(state_d) && (abort_q || (cmd_abort && wd_enable));
    ap_start_d = (state_d == ST_START);
    busy_d     = (state_d == ST_WAIT_IDLE) || is_supervised(state_d);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      num_runs_q   <= '0;
      runs_q       <= '0;
      ap_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      batch_done_q <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
      started_q    <= 1'b0;
      abort_q      <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_runs_q   <= num_runs_d;
      runs_q       <= runs_d;
      ap_start_q   <= ap_start_d;
      busy_q       <= busy_d;
      batch_done_q <= batch_done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      started_q    <= started_d;
      abort_q      <= abort_d;
      pend_q       <= pend_d;
    end
  end

  assign ap_start       = ap_start_q;
  assign busy           = busy_q;
  assign batch_done     = batch_done_q;
  assign runs_completed = runs_q;
  assign err            = err_q;
  assign err_code       = err_code_q;

endmodule
